// File: rtl/bcp_imply_arb.sv
// ---------------------------------------------------------------------------
// bcp_imply_arb
//   Collects implied literals from NUM_PE BCP engines and serializes them,
//   one per cycle, into the unit-clause queue (UCQ). Engines are served
//   round-robin. Each granted literal is filtered against everything still
//   in the implication FIFO:
//   - a zero (pruned) literal is dropped,
//   - a duplicate is dropped,
//   - a literal whose complement is already queued raises a conflict.
//   Engines can also signal a clause conflict directly. A conflict freezes
//   the block until the controller issues flush after backtracking.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   pe_imply_valid  per-PE request, held by the PE until acked
//   pe_imply_lit    per-PE literal, PE i at [i*LIT_W +: LIT_W], signed, 0=invalid
//   pe_conflict     per-PE clause-conflict pulse
//   pe_imply_ack    one-hot grant, combinational in the accepting cycle
//   ucq_lit         FIFO head literal (0 when ucq_valid is low)
//   ucq_valid       head valid (non-empty and not in conflict)
//   ucq_ready       UCQ accepts the head this cycle
//   flush           clear FIFO, conflict and round-robin pointer
//   conflict_out    sticky conflict flag
//   conflict_pe     PE that caused the first conflict
//   fifo_count      FIFO occupancy
//   busy            FIFO non-empty or any request pending
// ---------------------------------------------------------------------------
module bcp_imply_arb #(
  parameter int NUM_PE     = 4,
  parameter int LIT_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PE-1:0]             pe_imply_valid,
  input  logic [NUM_PE*LIT_W-1:0]       pe_imply_lit,
  input  logic [NUM_PE-1:0]             pe_conflict,
  output logic [NUM_PE-1:0]             pe_imply_ack,
  output logic [LIT_W-1:0]              ucq_lit,
  output logic                          ucq_valid,
  input  logic                          ucq_ready,
  input  logic                          flush,
  output logic                          conflict_out,
  output logic [$clog2(NUM_PE)-1:0]     conflict_pe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PE_W  = $clog2(NUM_PE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN,
    ST_CONFLICT
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state_reg;
  logic [PE_W-1:0]    rr_ptr_reg;
  logic               conflict_reg;
  logic [PE_W-1:0]    conflict_pe_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  // Kept in flops: every slot is compared against the granted literal in
  // parallel, which a RAM could not provide.
  logic [LIT_W-1:0]   mem_reg [FIFO_DEPTH];

  // -------------------------------------------------------------------------
  // Per-PE literal unpacking
  // -------------------------------------------------------------------------
  logic [LIT_W-1:0] pe_lit [NUM_PE];

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_unpack
      assign pe_lit[gi] = pe_imply_lit[gi*LIT_W +: LIT_W];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin winner search: first requester at or after rr_ptr_reg
  // -------------------------------------------------------------------------
  logic            grant_found;
  logic [PE_W-1:0] grant_idx;
  logic [PE_W-1:0] scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      scan_idx = PE_W'((int'(rr_ptr_reg) + k) % NUM_PE);
      if (!grant_found && pe_imply_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Lowest-index engine reporting a clause conflict
  logic [PE_W-1:0] pe_conf_idx;

  always_comb begin
    pe_conf_idx = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (pe_conflict[k]) begin
        pe_conf_idx = PE_W'(k);
      end
    end
  end

  logic any_pe_conflict;
  logic fifo_full;
  logic grant_en;

  assign any_pe_conflict = |pe_conflict;
  assign fifo_full       = (count_reg >= CNT_W'(FIFO_DEPTH));

  // Registered count only: a pop in this cycle does not make room for a push.
  // rst_n gates the grant so no PE sees an ack while reset is held.
  assign grant_en = rst_n && (state_reg == ST_RUN) && !flush &&
                    !any_pe_conflict && !fifo_full && grant_found;

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_ack
      assign pe_imply_ack[gi] = grant_en && (grant_idx == PE_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Filtering of the granted literal against all live FIFO slots
  // (including the head, even if it is popped in this same cycle)
  // -------------------------------------------------------------------------
  logic [LIT_W-1:0]      grant_lit;
  logic [LIT_W-1:0]      neg_lit;
  logic [FIFO_DEPTH-1:0] slot_valid;
  logic [FIFO_DEPTH-1:0] dup_hit;
  logic [FIFO_DEPTH-1:0] neg_hit;

  assign grant_lit = pe_lit[grant_idx];
  assign neg_lit   = -grant_lit;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] slot_off;
      // Distance from the head; wraps naturally as FIFO_DEPTH is a power of 2
      assign slot_off       = PTR_W'(gi) - rd_ptr_reg;
      assign slot_valid[gi] = ({1'b0, slot_off} < count_reg);
      assign dup_hit[gi]    = slot_valid[gi] && (mem_reg[gi] == grant_lit);
      assign neg_hit[gi]    = slot_valid[gi] && (mem_reg[gi] == neg_lit);
    end
  endgenerate

  logic lit_zero;
  logic lit_dup;
  logic lit_contra;
  logic push;
  logic contra_fire;
  logic pop;

  assign lit_zero    = (grant_lit == '0);
  assign lit_dup     = |dup_hit;
  assign lit_contra  = |neg_hit;
  assign push        = grant_en && !lit_zero && !lit_dup && !lit_contra;
  assign contra_fire = grant_en && !lit_zero && !lit_dup &&  lit_contra;
  assign pop         = ucq_valid && ucq_ready && !flush;

  logic [PE_W-1:0] rr_next;
  assign rr_next = (grant_idx == PE_W'(NUM_PE - 1)) ? '0 : grant_idx + PE_W'(1);

  // -------------------------------------------------------------------------
  // Control FSM, pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_RUN;
      rr_ptr_reg      <= '0;
      conflict_reg    <= 1'b0;
      conflict_pe_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (flush) begin
      state_reg       <= ST_RUN;
      rr_ptr_reg      <= '0;
      conflict_reg    <= 1'b0;
      conflict_pe_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        ST_RUN: begin
          if (any_pe_conflict) begin
            state_reg       <= ST_CONFLICT;
            conflict_reg    <= 1'b1;
            conflict_pe_reg <= pe_conf_idx;
          end else if (contra_fire) begin
            state_reg       <= ST_CONFLICT;
            conflict_reg    <= 1'b1;
            conflict_pe_reg <= grant_idx;
          end
          if (grant_en) begin
            rr_ptr_reg <= rr_next;
          end
        end
        // Frozen until flush; later conflicts do not overwrite the source
        ST_CONFLICT: begin
          state_reg <= ST_CONFLICT;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // FIFO storage: contents need no reset, occupancy says what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= grant_lit;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ucq_valid    = (count_reg != '0) && (state_reg == ST_RUN);
  assign ucq_lit      = ucq_valid ? mem_reg[rd_ptr_reg] : '0;
  assign conflict_out = conflict_reg;
  assign conflict_pe  = conflict_pe_reg;
  assign fifo_count   = count_reg;
  assign busy         = (count_reg != '0) || (|pe_imply_valid);

endmodule

// File: tb/tb_bcp_imply_arb.sv
// ---------------------------------------------------------------------------
// tb_bcp_imply_arb
//   Directed stimulus for bcp_imply_arb. Literals expected on the UCQ are
//   pushed into a scoreboard queue when their ack is observed; a monitor
//   pops and compares on every UCQ handshake. Control outputs (ack, count,
//   conflict) are checked directly against hand-computed values.
//   Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_bcp_imply_arb;

  localparam int NUM_PE     = 4;
  localparam int LIT_W      = 8;
  localparam int FIFO_DEPTH = 8;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_PE-1:0]           pe_imply_valid;
  logic [NUM_PE*LIT_W-1:0]     pe_imply_lit;
  logic [NUM_PE-1:0]           pe_conflict;
  logic [NUM_PE-1:0]           pe_imply_ack;
  logic [LIT_W-1:0]            ucq_lit;
  logic                        ucq_valid;
  logic                        ucq_ready;
  logic                        flush;
  logic                        conflict_out;
  logic [$clog2(NUM_PE)-1:0]   conflict_pe;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        busy;

  int vec_cnt;
  int err_cnt;
  logic [LIT_W-1:0] sb_q[$];

  bcp_imply_arb #(
    .NUM_PE     (NUM_PE),
    .LIT_W      (LIT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pe_imply_valid (pe_imply_valid),
    .pe_imply_lit   (pe_imply_lit),
    .pe_conflict    (pe_conflict),
    .pe_imply_ack   (pe_imply_ack),
    .ucq_lit        (ucq_lit),
    .ucq_valid      (ucq_valid),
    .ucq_ready      (ucq_ready),
    .flush          (flush),
    .conflict_out   (conflict_out),
    .conflict_pe    (conflict_pe),
    .fifo_count     (fifo_count),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lit(input int pe, input logic [LIT_W-1:0] v);
    pe_imply_lit[pe*LIT_W +: LIT_W] = v;
  endtask

  // Scoreboard monitor: every UCQ handshake must match the oldest expected lit
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ucq_valid && ucq_ready) begin
        if (sb_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL ucq_unexpected: got %0h, expected no output", ucq_lit);
        end else begin
          logic [LIT_W-1:0] exp_lit;
          exp_lit = sb_q.pop_front();
          check("ucq_lit", 32'(ucq_lit), 32'(exp_lit));
          $display("ucq pop lit=%0d expected=%0d", $signed(ucq_lit), $signed(exp_lit));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n          = 1'b0;
    pe_imply_valid = '0;
    pe_imply_lit   = '0;
    pe_conflict    = '0;
    ucq_ready      = 1'b0;
    flush          = 1'b0;

    // ---------------- Reset state ----------------
    @(negedge clk);
    check("rst_ack",      32'(pe_imply_ack), 32'h0);
    check("rst_valid",    32'(ucq_valid),    32'h0);
    check("rst_lit",      32'(ucq_lit),      32'h0);
    check("rst_count",    32'(fifo_count),   32'h0);
    check("rst_conflict", 32'(conflict_out), 32'h0);
    check("rst_cpe",      32'(conflict_pe),  32'h0);
    cyc();
    rst_n = 1'b1;

    // ---------------- Single request ----------------
    cyc();
    ucq_ready = 1'b1;
    pe_imply_valid = 4'b0100;
    set_lit(2, 8'd5);
    @(negedge clk);
    check("single_ack", 32'(pe_imply_ack), 32'h4);
    sb_q.push_back(8'd5);
    cyc();
    pe_imply_valid = '0;
    @(negedge clk);
    check("single_valid", 32'(ucq_valid),  32'h1);
    check("single_cnt1",  32'(fifo_count), 32'h1);
    cyc();
    @(negedge clk);
    check("single_cnt0",  32'(fifo_count), 32'h0);

    // ---------------- Round-robin (flush first to bring rr_ptr to 0) --------
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    pe_imply_valid = 4'b1111;
    for (int i = 0; i < NUM_PE; i++) set_lit(i, 8'(i + 1));
    for (int k = 0; k < NUM_PE; k++) begin
      @(negedge clk);
      check("rr_ack", 32'(pe_imply_ack), 32'(1 << k));
      sb_q.push_back(8'(k + 1));
      cyc();
    end
    pe_imply_valid = '0;
    repeat (4) cyc();
    @(negedge clk);
    check("rr_drain_cnt", 32'(fifo_count), 32'h0);

    // ---------------- Duplicate and contradiction (rr_ptr back at 0) --------
    cyc();
    ucq_ready = 1'b0;
    pe_imply_valid = 4'b0001;
    set_lit(0, 8'd7);
    @(negedge clk);
    check("dup_ack0", 32'(pe_imply_ack), 32'h1);
    sb_q.push_back(8'd7);
    cyc();
    pe_imply_valid = 4'b0010;
    set_lit(1, 8'd7);
    @(negedge clk);
    check("dup_ack1", 32'(pe_imply_ack), 32'h2);
    check("dup_cnt_a", 32'(fifo_count),  32'h1);
    cyc();
    pe_imply_valid = 4'b0100;
    set_lit(2, 8'hF9);  // -7
    @(negedge clk);
    check("contra_ack", 32'(pe_imply_ack), 32'h4);
    check("dup_cnt_b",  32'(fifo_count),   32'h1);
    cyc();
    pe_imply_valid = 4'b1000;
    set_lit(3, 8'd9);
    @(negedge clk);
    check("contra_flag",  32'(conflict_out), 32'h1);
    check("contra_pe",    32'(conflict_pe),  32'h2);
    check("contra_valid", 32'(ucq_valid),    32'h0);
    check("contra_noack", 32'(pe_imply_ack), 32'h0);
    check("contra_cnt",   32'(fifo_count),   32'h1);
    cyc();
    pe_imply_valid = '0;
    flush = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("flush_noack", 32'(pe_imply_ack), 32'h0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("flush_cnt",  32'(fifo_count),   32'h0);
    check("flush_conf", 32'(conflict_out), 32'h0);
    check("flush_cpe",  32'(conflict_pe),  32'h0);

    // ---------------- Full / backpressure ----------------
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      cyc();
      pe_imply_valid = 4'(1 << (k % NUM_PE));
      set_lit(k % NUM_PE, 8'(10 + k));
      @(negedge clk);
      check("full_fill_ack", 32'(pe_imply_ack), 32'(1 << (k % NUM_PE)));
      sb_q.push_back(8'(10 + k));
    end
    cyc();
    pe_imply_valid = 4'b0010;
    set_lit(1, 8'd30);
    @(negedge clk);
    check("full_cnt",    32'(fifo_count),   32'h8);
    check("full_noack",  32'(pe_imply_ack), 32'h0);
    cyc();
    ucq_ready = 1'b1;
    @(negedge clk);
    check("full_pop_noack", 32'(pe_imply_ack), 32'h0);
    cyc();
    @(negedge clk);
    check("full_cnt7",  32'(fifo_count),   32'h7);
    check("full_ack9",  32'(pe_imply_ack), 32'h2);
    sb_q.push_back(8'd30);
    cyc();
    pe_imply_valid = '0;
    for (int w = 0; w < 20; w++) begin
      if (fifo_count == 0) break;
      cyc();
    end
    @(negedge clk);
    check("full_drain_cnt", 32'(fifo_count), 32'h0);

    // ---------------- PE conflict vs grant (rr_ptr now 2) ----------------
    cyc();
    pe_conflict = 4'b1000;
    pe_imply_valid = 4'b0010;
    set_lit(1, 8'd40);
    @(negedge clk);
    check("pec_noack", 32'(pe_imply_ack), 32'h0);
    cyc();
    pe_conflict = '0;
    flush = 1'b1;
    @(negedge clk);
    check("pec_flag",    32'(conflict_out), 32'h1);
    check("pec_pe",      32'(conflict_pe),  32'h3);
    check("pec_fl_noack", 32'(pe_imply_ack), 32'h0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("pec_cnt",  32'(fifo_count),   32'h0);
    check("pec_conf", 32'(conflict_out), 32'h0);
    check("pec_ack",  32'(pe_imply_ack), 32'h2);
    sb_q.push_back(8'd40);
    cyc();
    pe_imply_valid = '0;
    repeat (2) cyc();

    // ---------------- Asynchronous reset mid-stream ----------------
    ucq_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pe_imply_valid = 4'b0001;
      set_lit(0, 8'(50 + k));
      @(negedge clk);
      check("ar_fill_ack", 32'(pe_imply_ack), 32'h1);
      sb_q.push_back(8'(50 + k));
      cyc();
    end
    set_lit(0, 8'd53);
    @(negedge clk);
    check("ar_cnt3", 32'(fifo_count), 32'h3);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("ar_cnt0",  32'(fifo_count),   32'h0);
    check("ar_valid", 32'(ucq_valid),    32'h0);
    check("ar_lit",   32'(ucq_lit),      32'h0);
    check("ar_ack",   32'(pe_imply_ack), 32'h0);
    check("ar_conf",  32'(conflict_out), 32'h0);
    cyc();
    pe_imply_valid = '0;
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    check("ar_post_cnt", 32'(fifo_count), 32'h0);

    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bcp_imply_arb.md
Name: bcp_imply_arb

Overview:
- Collects implications and conflicts from NUM_PE bcp_pe engines and serializes implications, one per cycle, into the unit-clause queue input.
- Round-robin arbitration across PEs; small internal FIFO; duplicate implications dropped.
- Contradictory implications (l and -l both pending) are flagged as a conflict.
- On conflict, stops forwarding and holds state until the controller issues flush after backtrack.

Parameters:
NUM_PE, 4, number of BCP engines served
LIT_W, 8, literal width; two's-complement signed, 0 = invalid/pruned
FIFO_DEPTH, 8, implication FIFO entries (power of 2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
pe_imply_valid  input  NUM_PE  per-PE implication request; PE holds it until acked
pe_imply_lit  input  NUM_PE*LIT_W  per-PE implied literal; PE i at bits [i*LIT_W +: LIT_W]
pe_conflict  input  NUM_PE  per-PE clause-conflict pulse
pe_imply_ack  output  NUM_PE  one-hot grant; combinational, same cycle as the accepted request
ucq_lit  output  LIT_W  FIFO head literal
ucq_valid  output  1  head valid
ucq_ready  input  1  UCQ accepts head
flush  input  1  clear FIFO, conflict and pointer (post-backtrack)
conflict_out  output  1  sticky conflict flag
conflict_pe  output  $clog2(NUM_PE)  source PE of the first conflict
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
busy  output  1  fifo_count!=0 or any pe_imply_valid

Behaviour:
- Reset: FIFO empty, fifo_count=0, rr_ptr=0, state=RUN, conflict_out=0, conflict_pe=0, ucq_valid=0, ucq_lit=0, pe_imply_ack=0.
- States: RUN, CONFLICT.
- Priority order, highest first: flush, then conflict detection, then grant/push, then pop.
- flush (either state): next cycle FIFO empty, rr_ptr=0, state=RUN, conflict_out=0, conflict_pe=0. No ack and no pop in the flush cycle.
- RUN, grant:
  - Only when fifo_count<FIFO_DEPTH, evaluated on the registered count. A pop in the same cycle does not free a slot for that cycle.
  - Winner is the first requesting PE at or after rr_ptr, modulo NUM_PE.
  - pe_imply_ack[winner]=1 in that cycle; rr_ptr<=winner+1 (wraps).
- Granted literal L, filtering against all current FIFO entries, including the head being popped this cycle:
  - L==0: acked, dropped.
  - L equals an entry: acked, dropped (duplicate).
  - -L equals an entry: acked, not pushed; conflict raised with conflict_pe=winner.
  - Otherwise pushed. Visible at ucq_lit/ucq_valid next cycle (1-cycle latency from ack).
- RUN, PE conflict: if any pe_conflict bit is set, state<=CONFLICT, conflict_out<=1, conflict_pe<=lowest set index. No grant that cycle.
- CONFLICT:
  - pe_imply_ack=0 and ucq_valid=0; FIFO contents frozen.
  - Further conflicts are ignored and conflict_pe keeps the first source.
  - Exit only via flush.
- Pop: ucq_valid = (fifo_count!=0) && state==RUN. Pop on ucq_valid && ucq_ready. ucq_lit=0 whenever ucq_valid=0.
- Push and pop in the same cycle: count unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH.
- Full: no ack while full; requesters wait, with valid held.
- Reset mid-operation: immediately returns to reset values; partially acked PEs are the PE's concern.

Test Plan:
- Single request: PE2 requests lit 5 with ucq_ready=1 -> ack[2] in cycle 0; ucq_valid=1, ucq_lit=5 in cycle 1; fifo_count returns to 0 after the pop.
- Round-robin: all 4 PEs hold lits 1,2,3,4 continuously, rr_ptr=0 -> acks to PE0,1,2,3 on consecutive cycles; UCQ receives 1,2,3,4 in order.
- Duplicate and contradiction: push 7, then another PE requests 7 -> acked, fifo_count stays 1; then a request of -7 -> acked, conflict_out=1, conflict_pe=that PE, ucq_valid=0.
- Full/backpressure: ucq_ready=0, push 8 distinct lits -> fifo_count=8, 9th request not acked; raise ucq_ready -> one pop, 9th acked the cycle after count drops to 7.
- PE conflict vs grant: same cycle pe_conflict[3]=1 and pe_imply_valid[1]=1 -> no ack, conflict_pe=3; flush next cycle -> fifo_count=0, conflict_out=0, PE1 acked in the following cycle.
- Async reset: assert rst_n=0 mid-stream with fifo_count=3 -> outputs zero immediately, without waiting for a clock edge.
